pc_stack_unit: RTL

//  Parametrised program-counter block for the CPU datapath, next generation of the PC stage.

---
 rtl/pc_stack_if.sv | 27 ++
 rtl/pc_stack_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// Control-unit to PC-stage bundle: next-PC controls in, PC, latched copy and stack status out.
interface pc_stack_if #(
   parameter int ADDR_W = 14,
   parameter int SP_W   = 3
);
   logic              ready_i;
   logic [2:0]        op_i;
   logic              br_taken_i;
   logic [ADDR_W-1:0] b_off_i;
   logic [ADDR_W-1:0] jump_ad_i;
   logic              pc_read_i;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] out_o;
   logic [SP_W-1:0]   sp_o;
   logic              stk_ovf_o;
   logic              stk_unf_o;

   modport master (
      output ready_i, op_i, br_taken_i, b_off_i, jump_ad_i, pc_read_i,
      input  pc_o, out_o, sp_o, stk_ovf_o, stk_unf_o
   );

   modport slave (
      input  ready_i, op_i, br_taken_i, b_off_i, jump_ad_i, pc_read_i,
      output pc_o, out_o, sp_o, stk_ovf_o, stk_unf_o
   );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, ready-based stall and read-latched PC copy.
module pc_stack_unit #(
   parameter int                ADDR_W      = 14,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input logic       clk,
   input logic       reset,
   pc_stack_if.slave bus
);
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] out_q, out_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] top_val;
   logic              push;

   assign pc_inc = pc_q + ADDR_W'(1);

   // Entry just below the occupancy pointer; compare-based mux keeps index widths exact.
   always_comb begin
      top_val = stack_q[0];
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) top_val = stack_q[i];
      end
   end

   // Next-PC, stack pointer and sticky flag selection; everything holds when stalled.
   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      out_d = bus.pc_read_i ? pc_q : out_q;
      if (bus.ready_i) begin
         case (bus.op_i)
            OP_BRANCH: pc_d = bus.br_taken_i ? (pc_q + bus.b_off_i) : pc_inc;
            OP_JUMP:   pc_d = bus.jump_ad_i;
            OP_CALL: begin
               pc_d = bus.jump_ad_i;
               if (sp_q == SP_W'(STACK_DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  push = 1'b1;
                  sp_d = sp_q + SP_W'(1);
               end
            end
            OP_RET: begin
               if (sp_q == '0) begin
                  unf_d = 1'b1;
                  pc_d  = pc_inc;
               end else begin
                  pc_d = top_val;
                  sp_d = sp_q - SP_W'(1);
               end
            end
            default:   pc_d = pc_inc;
         endcase
      end
   end

   // Architectural state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         out_q <= '0;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         out_q <= out_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack storage; contents are don't-care after reset since sp gates every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (!reset && push && (sp_q == SP_W'(i))) stack_q[i] <= pc_inc;
      end
   end

   assign bus.pc_o      = pc_q;
   assign bus.out_o     = out_q;
   assign bus.sp_o      = sp_q;
   assign bus.stk_ovf_o = ovf_q;
   assign bus.stk_unf_o = unf_q;
endmodule
